// File: rtl/alm_soa_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alm_soa_pipe
// Purpose  : Three-stage pipelined approximate signed multiplier using the
//            ALM (approximate logarithmic multiplier) scheme with a
//            set-one-adder (SOA) on the low M log-fraction bits. Valid/ready
//            handshake on both sides; a global advance enable shifts or holds
//            the whole pipe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i    in   1      clock, rising edge
//   rst_ni   in   1      asynchronous active-low reset
//   valid_i  in   1      operand pair valid
//   ready_o  out  1      operands accepted this cycle
//   x_i,y_i  in   W      signed operands
//   tag_i    in   TAG_W  sideband tag
//   valid_o  out  1      result valid
//   ready_i  in   1      downstream accepts result
//   p_o      out  2W     signed approximate product
//   tag_o    out  TAG_W  tag travelling with p_o
// Build option
//   ALM_EXACT_ABS_EN  defined: two's-complement abs/negate (-1 -> magnitude 1)
//                     undefined: ones'-complement abs/sign (-1 -> product 0)
// ============================================================================
module alm_soa_pipe #(
  parameter int W     = 8,
  parameter int F     = 3,
  parameter int M     = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [W-1:0]     x_i,
  input  logic [W-1:0]     y_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [2*W-1:0]   p_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int KW = $clog2(W);   // leading-one index width
  localparam int EW = KW + 1;      // exponent of the log sum (0..2W-1)
  localparam int FM = F - M;       // fraction bits handled by the real adder
  localparam int LW = EW + FM;     // log-sum width
  localparam int PW = 2 * W;       // product width
  localparam int UW = 3 * W;       // room for the widest antilog shift

  // Position of the most significant set bit; 0 for a zero operand (masked
  // later by the zero flag).
  function automatic logic [KW-1:0] lead_idx(input logic [W-1:0] a);
    lead_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) lead_idx = KW'(i);
    end
  endfunction

  // Bits below the leading one, left aligned, top F kept.
  function automatic logic [F-1:0] frac_bits(input logic [W-1:0] a,
                                             input logic [KW-1:0] k);
    logic [W-1:0] n;
    n = a << (KW'(W - 1) - k);
    frac_bits = n[W-2 -: F];
  endfunction

  logic w_en;
  assign w_en    = ~valid_o | ready_i;
  assign ready_o = w_en;

  // ---------------- S1: sign / magnitude ----------------
  logic         w_sx, w_sy;
  logic [W-1:0] w_ax, w_ay;
  assign w_sx = x_i[W-1];
  assign w_sy = y_i[W-1];
`ifdef ALM_EXACT_ABS_EN
  assign w_ax = (x_i ^ {W{w_sx}}) + W'(w_sx);
  assign w_ay = (y_i ^ {W{w_sy}}) + W'(w_sy);
`else
  assign w_ax = x_i ^ {W{w_sx}};
  assign w_ay = y_i ^ {W{w_sy}};
`endif

  logic             r_v1, r_z1, r_s1;
  logic [W-1:0]     r_ax, r_ay;
  logic [TAG_W-1:0] r_t1;

  // ---------------- S2: log domain add ----------------
  logic [KW-1:0] w_kx, w_ky;
  logic [F-1:0]  w_fx, w_fy;
  logic [LW-1:0] w_lx, w_ly, w_l;
  assign w_kx = lead_idx(r_ax);
  assign w_ky = lead_idx(r_ay);
  assign w_fx = frac_bits(r_ax, w_kx);
  assign w_fy = frac_bits(r_ay, w_ky);
  assign w_lx = {1'b0, w_kx, w_fx[F-1:M]};
  assign w_ly = {1'b0, w_ky, w_fy[F-1:M]};
  // SOA: the low M bits are not added; only their top-bit AND feeds a carry.
  // A fraction carry naturally ripples into the exponent field.
  assign w_l  = w_lx + w_ly + LW'(w_fx[M-1] & w_fy[M-1]);

  logic             r_v2, r_z2, r_s2;
  logic [LW-1:0]    r_l;
  logic [TAG_W-1:0] r_t2;

  // ---------------- S3: antilog and sign ----------------
  logic [EW-1:0] w_k;
  logic [W-2:0]  w_field;
  logic [UW-1:0] w_mant;
  logic [PW-1:0] w_mag, w_sgn, w_p;
  assign w_k     = r_l[LW-1:FM];
  // Unfilled fraction bits are forced high (set-one compensation).
  assign w_field = {r_l[FM-1:0], {(W - 1 - FM){1'b1}}};
  assign w_mant  = {{PW{1'b0}}, 1'b1, w_field};
  assign w_mag   = PW'((w_mant << w_k) >> (W - 1));
`ifdef ALM_EXACT_ABS_EN
  assign w_sgn   = r_s2 ? (-w_mag) : w_mag;
`else
  assign w_sgn   = w_mag ^ {PW{r_s2}};
`endif
  assign w_p     = r_z2 ? '0 : w_sgn;

  logic             r_v3;
  logic [PW-1:0]    r_p;
  logic [TAG_W-1:0] r_t3;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v1 <= 1'b0;
      r_z1 <= 1'b0;
      r_s1 <= 1'b0;
      r_ax <= '0;
      r_ay <= '0;
      r_t1 <= '0;
      r_v2 <= 1'b0;
      r_z2 <= 1'b0;
      r_s2 <= 1'b0;
      r_l  <= '0;
      r_t2 <= '0;
      r_v3 <= 1'b0;
      r_p  <= '0;
      r_t3 <= '0;
    end else if (w_en) begin
      // Whole pipe shifts together, bubbles included.
      r_v1 <= valid_i;
      r_z1 <= (w_ax == '0) | (w_ay == '0);
      r_s1 <= w_sx ^ w_sy;
      r_ax <= w_ax;
      r_ay <= w_ay;
      r_t1 <= tag_i;
      r_v2 <= r_v1;
      r_z2 <= r_z1;
      r_s2 <= r_s1;
      r_l  <= w_l;
      r_t2 <= r_t1;
      r_v3 <= r_v2;
      r_p  <= w_p;
      r_t3 <= r_t2;
    end
  end

  assign valid_o = r_v3;
  assign p_o     = r_p;
  assign tag_o   = r_t3;

endmodule
`default_nettype wire
